// File: rtl/rca_result_display_pkg.sv
// Shared types and constants for the adder-result display: scan states,
// active-low digit enables and the active-low seven-segment glyph table.
package rca_result_display_pkg;

  typedef enum logic [1:0] {
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } scan_state_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Segments ordered g..a, active-low; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'b0001110, // F
    7'b0000110, // E
    7'b0100001, // d
    7'b1000110, // C
    7'b0000011, // b
    7'b0001000, // A
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

endpackage

// File: rtl/rca_result_display_if.sv
// Adder-side inputs and display-side outputs of the result display.
interface rca_result_display_if;

  logic [3:0] sum_in;
  logic       c_in;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output sum_in, c_in, load,
    input  busy, seg, dp, an
  );

  modport slave (
    input  sum_in, c_in, load,
    output busy, seg, dp, an
  );

endinterface

// File: rtl/seg_glyph_decoder.sv
// Combinational nibble-to-glyph decoder with a blanking override.
module seg_glyph_decoder
  import rca_result_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : GLYPH_TBL[nibble];

endmodule

// File: rtl/rca_result_display.sv
// Converts the 5-bit adder result to BCD by sequential double dabble and
// multiplexes decimal tens/units plus hex nibbles onto a 4-digit display.
module rca_result_display
  import rca_result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  rca_result_display_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Bit layout of the shift register: tens [12:9], units [8:5], binary [4:0].
  function automatic logic [12:0] dd_step(input logic [12:0] v);
    logic [12:0] a;
    a = v;
    if (a[8:5] >= 4'd5)  a[8:5]  = a[8:5]  + 4'd3;
    if (a[12:9] >= 4'd5) a[12:9] = a[12:9] + 4'd3;
    return {a[11:0], 1'b0};
  endfunction

  logic [4:0]       res_in;
  logic             busy;
  logic [2:0]       step_cnt;
  logic [12:0]      dd_p0;
  logic [12:0]      dd_nxt;
  logic [4:0]       cap_r;
  logic [3:0]       tens;
  logic [3:0]       units;
  logic [4:0]       hex_val;

  logic [CNT_W-1:0] refresh_cnt;
  logic             refresh_wrap;
  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [3:0]       an_nxt;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_dec;

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  assign res_in = {bus.c_in, bus.sum_in};
  assign dd_nxt = dd_step(dd_p0);

  // Conversion: capture on an idle LOAD, then five shift-add-3 steps; the
  // displayed digits only change together on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      step_cnt <= '0;
      dd_p0    <= '0;
      cap_r    <= '0;
      tens     <= '0;
      units    <= '0;
      hex_val  <= '0;
    end else if (busy) begin
      dd_p0    <= dd_nxt;
      step_cnt <= step_cnt + 3'd1;
      if (step_cnt == 3'd4) begin
        busy    <= 1'b0;
        tens    <= dd_nxt[12:9];
        units   <= dd_nxt[8:5];
        hex_val <= cap_r;
      end
    end else if (bus.load) begin
      busy     <= 1'b1;
      step_cnt <= '0;
      dd_p0    <= {8'd0, res_in};
      cap_r    <= res_in;
    end
  end

  assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      state       <= DIG0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
      state       <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    an_nxt    = AN_OFF;
    nibble    = 4'd0;
    blank     = 1'b0;
    case (state)
      DIG0: begin
        an_nxt = AN_DIG0;
        nibble = units;
        if (refresh_wrap) state_nxt = DIG1;
      end
      DIG1: begin
        an_nxt = AN_DIG1;
        nibble = tens;
        blank  = (tens == 4'd0);
        if (refresh_wrap) state_nxt = DIG2;
      end
      DIG2: begin
        an_nxt = AN_DIG2;
        nibble = hex_val[3:0];
        if (refresh_wrap) state_nxt = DIG3;
      end
      DIG3: begin
        an_nxt = AN_DIG3;
        nibble = {3'b000, hex_val[4]};
        if (refresh_wrap) state_nxt = DIG0;
      end
      default: begin
        state_nxt = DIG0;
      end
    endcase
  end

  seg_glyph_decoder u_glyph (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_dec)
  );

  // Output stage: registered digit enable and segments for the current digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_dec;
      dp_q  <= 1'b1;
    end
  end

  assign bus.busy = busy;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;

endmodule

// File: tb/tb_rca_result_display.sv
// Randomized and directed bench for rca_result_display against a
// value-level model of the displayed result.
module tb_rca_result_display;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_result_display_if bus ();

  rca_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input int idx, input int val);
    case (idx)
      0: return glyph(val % 10);
      1: return (val / 10 == 0) ? 7'b1111111 : glyph(val / 10);
      2: return glyph(val % 16);
      default: return glyph(val / 16);
    endcase
  endfunction

  // Model: edges since reset, shown value, pending value and remaining steps.
  int   m_edges, m_disp, m_pend, m_left;
  bit   m_busy;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_busy;

  task automatic model_reset();
    m_edges = 0; m_disp = 0; m_pend = 0; m_left = 0; m_busy = 0;
    exp_an = 4'b1111; exp_seg = 7'b1111111; exp_busy = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input int r);
    int idx;
    idx = (m_edges / DIV) % 4;
    exp_an  = ~(4'b0001 << idx);
    exp_seg = digit_seg(idx, m_disp);
    m_edges++;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_disp = m_pend;
      end
    end else if (ld) begin
      m_busy = 1;
      m_left = 5;
      m_pend = r;
    end
    exp_busy = m_busy;
  endtask

  // Called at a negedge: drive inputs for the next posedge, then check after it.
  task automatic cycle(input logic ld, input int r);
    bus.load   = ld;
    bus.sum_in = r[3:0];
    bus.c_in   = r[4];
    model_edge(ld, r);
    @(negedge clk);
    chk("an", bus.an, exp_an);
    chk("seg", bus.seg, exp_seg);
    chk("busy", bus.busy, exp_busy);
    chk("dp", bus.dp, 1'b1);
  endtask

  logic [6:0] seen [4];

  task automatic capture_digits();
    for (int k = 0; k < 4 * DIV; k++) begin
      cycle(1'b0, 0);
      case (bus.an)
        4'b1110: seen[0] = bus.seg;
        4'b1101: seen[1] = bus.seg;
        4'b1011: seen[2] = bus.seg;
        4'b0111: seen[3] = bus.seg;
        default: chk("an_onehot", bus.an, exp_an);
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [6:0] d2, input logic [6:0] d3);
    capture_digits();
    chk({tag, "_dig0"}, seen[0], d0);
    chk({tag, "_dig1"}, seen[1], d1);
    chk({tag, "_dig2"}, seen[2], d2);
    chk({tag, "_dig3"}, seen[3], d3);
  endtask

  // Asynchronous reset pulse in the low phase, spanning one rising edge.
  task automatic async_reset();
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_an", bus.an, 4'b1111);
    chk("rst_seg", bus.seg, 7'b1111111);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.sum_in = 4'd0; bus.c_in = 1'b0;
    model_reset();
    #1;
    chk("init_an", bus.an, 4'b1111);
    chk("init_seg", bus.seg, 7'b1111111);
    chk("init_busy", bus.busy, 1'b0);
    chk("init_dp", bus.dp, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Refresh wrap and first post-reset digit
    for (int k = 1; k <= 4 * DIV + 1; k++) begin
      cycle(1'b0, 0);
      if (k == 1) begin
        chk("first_an", bus.an, 4'b1110);
        chk("first_seg", bus.seg, 7'b1000000);
      end
      if (k == DIV + 1)     chk("wrap_dig1", bus.an, 4'b1101);
      if (k == 2 * DIV + 1) chk("wrap_dig2", bus.an, 4'b1011);
      if (k == 3 * DIV + 1) chk("wrap_dig3", bus.an, 4'b0111);
      if (k == 4 * DIV + 1) chk("wrap_ret", bus.an, 4'b1110);
    end

    // Nominal load of 27
    cycle(1'b1, 27);
    for (int k = 0; k < 5; k++) cycle(1'b0, 0);
    chk("nom_busy_done", bus.busy, 1'b0);
    check_digits("nom", 7'b1111000, 7'b0100100, 7'b0000011, 7'b1111001);

    // Leading-zero blank for 9
    cycle(1'b1, 9);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0);
    check_digits("blank", 7'b0010000, 7'b1111111, 7'b0010000, 7'b1000000);

    // LOAD during a conversion is dropped
    cycle(1'b1, 5);
    cycle(1'b0, 0);
    cycle(1'b1, 31);
    for (int k = 0; k < 8; k++) cycle(1'b0, 0);
    check_digits("reject", 7'b0010010, 7'b1111111, 7'b0010010, 7'b1000000);
    cycle(1'b1, 31);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0);
    check_digits("clean31", 7'b1111001, 7'b0110000, 7'b0001110, 7'b1111001);

    // Reset mid-scan
    for (int k = 0; k < 3; k++) cycle(1'b0, 0);
    async_reset();
    cycle(1'b0, 0);
    chk("rel_an", bus.an, 4'b1110);
    chk("rel_seg", bus.seg, 7'b1000000);

    // Abort a conversion of 20 before it completes
    cycle(1'b1, 20);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    async_reset();
    for (int k = 0; k < 8; k++) cycle(1'b0, 0);
    chk("abort_busy", bus.busy, 1'b0);
    check_digits("abort", 7'b1000000, 7'b1111111, 7'b1000000, 7'b1000000);

    // Randomized loads, including loads on the busy-falling edge
    for (int k = 0; k < 600; k++) begin
      logic ld;
      int   r;
      ld = ($urandom_range(3) == 0);
      r  = int'($urandom_range(31));
      cycle(ld, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rca_result_display.md
RCA_RESULT_DISPLAY -- requirements
Module: rca_result_display

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clock cycles each digit stays enabled, minimum 2.
REQ-002 Port: CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: RST  in  1  reset; asynchronous and active-high.
REQ-004 Port: SUM_IN  in  4  sum bits from the upstream 4-bit ripple-carry adder.
REQ-005 Port: C_IN  in  1  carry-out from the upstream adder; forms result bit 4.
REQ-006 Port: LOAD  in  1  capture strobe; one-cycle pulse requests conversion of {C_IN,SUM_IN}.
REQ-007 Port: BUSY  out  1  high while a conversion is in progress.
REQ-008 Port: SEG  out  7  segments g..a, active-low, registered.
REQ-009 Port: DP  out  1  decimal point, active-low, registered.
REQ-010 Port: AN  out  4  digit enables, active-low, one-hot-low, registered.

Function
REQ-011 The block SHALL treat R = {C_IN,SUM_IN} as an unsigned 5-bit value, 0..31.
REQ-012 On a rising edge with LOAD=1 and BUSY=0, the block SHALL capture R and set BUSY=1.
REQ-013 A LOAD while BUSY=1 SHALL be ignored, with no capture, no restart and no queueing.
REQ-014 Conversion SHALL use sequential shift-add-3 (double dabble), one bit per cycle, for exactly 5 cycles.
REQ-015 Capture-edge timing: LOAD is sampled at edge N, steps run at edges N+1..N+5, and BUSY is 0 after edge N+5.
REQ-016 Tens, units and hex digits SHALL update atomically at edge N+5.
REQ-017 The previous display SHALL be held unchanged throughout a conversion.
REQ-018 A LOAD sampled at the edge where BUSY falls (BUSY=1 before that edge) SHALL be ignored.
REQ-019 Scan FSM states: DIG0, DIG1, DIG2, DIG3; the sequence is DIG0->DIG1->DIG2->DIG3->DIG0.
REQ-020 Scan advance: a refresh counter counts 0..REFRESH_DIV-1 and the FSM advances on the wrap from REFRESH_DIV-1 to 0.
REQ-021 Per state: DIG0 drives AN=1110 with decimal units; DIG1 drives AN=1101 with decimal tens.
REQ-022 Per state: DIG2 drives AN=1011 with the hex low nibble of R; DIG3 drives AN=0111 with the hex high nibble (0 or 1).
REQ-023 In DIG1, when tens=0, SEG SHALL be 1111111 (leading-zero blank); all other digits always show their value.
REQ-024 Hex glyphs SHALL be 0-9, A, b, C, d, E, F.
REQ-025 DP SHALL be 1 at all times.
REQ-026 Scanning SHALL continue uninterrupted during conversion and LOAD activity.

Reset
REQ-027 While RST=1: AN=1111, SEG=1111111, DP=1, BUSY=0, scan state DIG0, refresh counter 0, stored digits all 0.
REQ-028 The first rising edge after RST falls SHALL drive AN=1110 and SEG=1000000 (units 0).
REQ-029 RST asserted mid-conversion SHALL abort the conversion immediately, with no display update on release.

Structure
REQ-030 A shared package SHALL hold the scan-state enum, the AN one-hot-low constants and the 16-entry active-low glyph table.
REQ-031 A single sub-module, seg_glyph_decoder (4-bit nibble plus blank in, 7-bit SEG out, combinational), SHALL be instantiated once.

Verification
REQ-032 Reset check: assert RST mid-scan -> AN=1111, SEG=1111111, BUSY=0 asynchronously; release -> AN=1110, SEG=1000000 after the next edge.
REQ-033 Nominal load: SUM_IN=1011, C_IN=1, LOAD pulse -> BUSY high for 5 cycles, then scan shows DIG0 1111000 ('7'), DIG1 0100100 ('2'), DIG2 0000011 ('b'), DIG3 1111001 ('1').
REQ-034 Blanking: SUM_IN=1001, C_IN=0 -> DIG1 SEG=1111111, DIG0 0010000 ('9'), DIG3 1000000 ('0').
REQ-035 Busy rejection: load 5, then LOAD again 2 cycles later with R=31 -> display shows 05, hex 05; a later clean load of 31 -> display 31, hex 1F.
REQ-036 Refresh wrap: REFRESH_DIV=4 -> AN steps 1110, 1101, 1011, 0111 every 4 cycles and returns to 1110 after 16 cycles.
REQ-037 Abort check: pulse RST at edge N+3 of a conversion of 20 -> display remains 0 after release and BUSY=0.
